// File: rtl/risc32_cp0_regfile_if.sv
// CP0 access bus between the pipeline (execute reads, writeback writes) and the
// coprocessor-0 register file. The register file is the slave side.
interface risc32_cp0_regfile_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_o;

    modport master (output we_i, output waddr_i, output data_i, output raddr_i, input data_o);
    modport slave  (input we_i, input waddr_i, input data_i, input raddr_i, output data_o);
endinterface

// File: rtl/risc32_cp0_regfile.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC and the
// read-only PRId/Config, with exception entry and ERET handling.
module risc32_cp0_regfile #(
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_RST = 32'h0000_8000
) (
    input  logic                        clk,
    input  logic                        rst,
    risc32_cp0_regfile_if.slave         bus,
    input  logic [5:0]                  int_i,
    input  logic                        exc_valid_i,
    input  logic [4:0]                  exc_code_i,
    input  logic [31:0]                 exc_pc_i,
    input  logic                        exc_in_delayslot_i,
    input  logic                        eret_i,
    output logic [31:0]                 count_o,
    output logic [31:0]                 compare_o,
    output logic [31:0]                 status_o,
    output logic [31:0]                 cause_o,
    output logic [31:0]                 epc_o,
    output logic                        timer_int_o
);
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [4:0] REG_CONFIG  = 5'd16;

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic        r_timer_int;

    logic w_wr_count;
    logic w_wr_compare;
    logic w_wr_status;
    logic w_wr_cause;
    logic w_wr_epc;
    logic w_timer_hit;

    assign w_wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
    assign w_wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
    assign w_wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
    assign w_wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
    assign w_wr_epc     = bus.we_i && (bus.waddr_i == REG_EPC);
    assign w_timer_hit  = (r_compare != 32'd0) && (r_count == r_compare);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 32'd0;
            r_compare   <= 32'd0;
            r_status    <= 32'h1000_0000;
            r_cause     <= 32'd0;
            r_epc       <= 32'd0;
            r_timer_int <= 1'b0;
        end else begin
            r_count <= w_wr_count ? bus.data_i : r_count + 32'd1;

            // A Compare write both acknowledges and outranks a same-cycle match.
            if (w_wr_compare) begin
                r_compare   <= bus.data_i;
                r_timer_int <= 1'b0;
            end else if (w_timer_hit) begin
                r_timer_int <= 1'b1;
            end

            r_cause[15:10] <= int_i;

            if (exc_valid_i) begin
                if (!r_status[1]) begin
                    r_epc       <= exc_in_delayslot_i ? exc_pc_i - 32'd4 : exc_pc_i;
                    r_cause[31] <= exc_in_delayslot_i;
                    r_status[1] <= 1'b1;
                end
                r_cause[6:2] <= exc_code_i;
            end else if (eret_i) begin
                r_status[1] <= 1'b0;
            end else begin
                if (w_wr_status) begin
                    r_status <= bus.data_i;
                end
                if (w_wr_cause) begin
                    r_cause[23:22] <= bus.data_i[23:22];
                    r_cause[9:8]   <= bus.data_i[9:8];
                end
                if (w_wr_epc) begin
                    r_epc <= bus.data_i;
                end
            end
        end
    end

    always_comb begin
        bus.data_o = 32'd0;
        case (bus.raddr_i)
            REG_COUNT:   bus.data_o = r_count;
            REG_COMPARE: bus.data_o = r_compare;
            REG_STATUS:  bus.data_o = r_status;
            REG_CAUSE:   bus.data_o = r_cause;
            REG_EPC:     bus.data_o = r_epc;
            REG_PRID:    bus.data_o = PRID_VAL;
            REG_CONFIG:  bus.data_o = CONFIG_RST;
            default:     bus.data_o = 32'd0;
        endcase
    end

    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign timer_int_o = r_timer_int;
endmodule

// File: tb/tb_risc32_cp0_regfile.sv
// Scenario bench for the CP0 register file; expectations are queued when
// stimulus is driven and compared once the DUT state has updated.
module tb_risc32_cp0_regfile;
    localparam int S_DATA = 0, S_COUNT = 1, S_COMPARE = 2, S_STATUS = 3;
    localparam int S_CAUSE = 4, S_EPC = 5, S_TIMER = 6;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  int_i = '0;
    logic        exc_valid_i = 1'b0;
    logic [4:0]  exc_code_i = '0;
    logic [31:0] exc_pc_i = '0;
    logic        exc_in_delayslot_i = 1'b0;
    logic        eret_i = 1'b0;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;
    logic        timer_int_o;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t e;

    risc32_cp0_regfile_if bus();

    risc32_cp0_regfile dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .int_i              (int_i),
        .exc_valid_i        (exc_valid_i),
        .exc_code_i         (exc_code_i),
        .exc_pc_i           (exc_pc_i),
        .exc_in_delayslot_i (exc_in_delayslot_i),
        .eret_i             (eret_i),
        .count_o            (count_o),
        .compare_o          (compare_o),
        .status_o           (status_o),
        .cause_o            (cause_o),
        .epc_o              (epc_o),
        .timer_int_o        (timer_int_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_DATA:    return bus.data_o;
            S_COUNT:   return count_o;
            S_COMPARE: return compare_o;
            S_STATUS:  return status_o;
            S_CAUSE:   return cause_o;
            S_EPC:     return epc_o;
            default:   return {31'd0, timer_int_o};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.we_i = 1'b0;
        bus.waddr_i = '0;
        bus.data_i = '0;
        exc_valid_i = 1'b0;
        eret_i = 1'b0;
        exc_code_i = '0;
        exc_pc_i = '0;
        exc_in_delayslot_i = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1'b1;
        bus.waddr_i = a;
        bus.data_i = d;
    endtask

    task automatic test_reset();
        logic [4:0]  addrs [3] = '{5'd15, 5'd16, 5'd3};
        logic [31:0] vals  [3] = '{32'h004C_0102, 32'h0000_8000, 32'd0};
        idle();
        rst = 1'b1;
        tick();
        sb.push_back('{S_COUNT, 32'd0, "reset_count"});
        sb.push_back('{S_COMPARE, 32'd0, "reset_compare"});
        sb.push_back('{S_CAUSE, 32'd0, "reset_cause"});
        sb.push_back('{S_EPC, 32'd0, "reset_epc"});
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                idle();
                tick();
            end
            if (i == 5) begin
                sb.push_back('{S_COUNT, 32'd5, "idle5_count"});
                sb.push_back('{S_STATUS, 32'h1000_0000, "idle5_status"});
                sb.push_back('{S_TIMER, 32'd0, "idle5_timer"});
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observe(e.sel) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            bus.raddr_i = addrs[i];
            sb.push_back('{S_DATA, vals[i], "read_const"});
            #1;
            e = sb.pop_front();
            n_checks++;
            if (observe(e.sel) !== e.val) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h expected %h", e.name, addrs[i], observe(e.sel), e.val);
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [31:0] exp_seq [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i == 0) wr(5'd9, 32'hFFFF_FFFE);
            tick();
            sb.push_back('{S_COUNT, exp_seq[i], "count_wrap"});
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observe(e.sel) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s step %0d: got %h expected %h", e.name, i, observe(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_timer();
        logic [31:0] exp_cnt;
        for (int c = 0; c <= 31; c++) begin
            idle();
            case (c)
                0:  wr(5'd11, 32'd20);
                1:  wr(5'd9, 32'd0);
                26: wr(5'd11, 32'd50);
                27: wr(5'd9, 32'd48);
                30: wr(5'd11, 32'd100);
                default: ;
            endcase
            tick();
            if (c >= 1) begin
                exp_cnt = (c <= 26) ? ((c == 26) ? 32'd25 : 32'(c - 1)) : 32'(48 + c - 27);
                sb.push_back('{S_COUNT, exp_cnt, "timer_count"});
                sb.push_back('{S_TIMER, (c >= 22 && c <= 25) ? 32'd1 : 32'd0, "timer_int"});
            end
            if (c == 30) sb.push_back('{S_COMPARE, 32'd100, "compare_val"});
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observe(e.sel) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: got %h expected %h", e.name, c, observe(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_exception();
        for (int s = 0; s < 3; s++) begin
            idle();
            case (s)
                0: begin
                    exc_valid_i = 1'b1; exc_code_i = 5'h08;
                    exc_pc_i = 32'h0000_0100; exc_in_delayslot_i = 1'b1;
                    wr(5'd14, 32'hDEAD_BEEF);
                end
                1: begin
                    exc_valid_i = 1'b1; exc_code_i = 5'h0C;
                    exc_pc_i = 32'h0000_0200; exc_in_delayslot_i = 1'b0;
                end
                default: eret_i = 1'b1;
            endcase
            tick();
            case (s)
                0: begin
                    sb.push_back('{S_EPC, 32'h0000_00FC, "exc1_epc"});
                    sb.push_back('{S_CAUSE, 32'h8000_0020, "exc1_cause"});
                    sb.push_back('{S_STATUS, 32'h1000_0002, "exc1_status"});
                end
                1: begin
                    sb.push_back('{S_EPC, 32'h0000_00FC, "exc2_epc"});
                    sb.push_back('{S_CAUSE, 32'h8000_0030, "exc2_cause"});
                end
                default: sb.push_back('{S_STATUS, 32'h1000_0000, "eret_status"});
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observe(e.sel) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_cause_status();
        for (int s = 0; s < 4; s++) begin
            idle();
            int_i = 6'b101010;
            case (s)
                0: rst = 1'b1;
                1: wr(5'd13, 32'hFFFF_FFFF);
                2: begin
                    wr(5'd12, 32'hFFFF_FFFF);
                    exc_valid_i = 1'b1;
                end
                default: wr(5'd3, 32'h1234_5678);
            endcase
            tick();
            case (s)
                1: sb.push_back('{S_CAUSE, 32'h00C0_AB00, "cause_write"});
                2: begin
                    sb.push_back('{S_STATUS, 32'h1000_0002, "status_drop"});
                    sb.push_back('{S_CAUSE, 32'h00C0_AB00, "cause_after_exc"});
                end
                3: begin
                    bus.raddr_i = 5'd13;
                    sb.push_back('{S_DATA, 32'h00C0_AB00, "read_cause"});
                    #1;
                    bus.raddr_i = 5'd3;
                    sb.push_back('{S_DATA, 32'd0, "unmapped_write"});
                end
                default: ;
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.name == "unmapped_write") bus.raddr_i = 5'd3;
                else if (e.sel == S_DATA) bus.raddr_i = 5'd13;
                #1;
                n_checks++;
                if (observe(e.sel) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
        int_i = '0;
    endtask

    task automatic test_mid_reset();
        for (int s = 0; s < 7; s++) begin
            idle();
            case (s)
                0: rst = 1'b1;
                1: wr(5'd11, 32'd5);
                2: wr(5'd9, 32'd5);
                4: exc_valid_i = 1'b1;
                5: wr(5'd9, 32'd1234);
                6: begin
                    rst = 1'b1;
                    wr(5'd9, 32'd77);
                    exc_valid_i = 1'b1;
                    int_i = 6'b111111;
                end
                default: ;
            endcase
            tick();
            case (s)
                3: sb.push_back('{S_TIMER, 32'd1, "pre_timer_set"});
                5: begin
                    sb.push_back('{S_COUNT, 32'd1234, "pre_count"});
                    sb.push_back('{S_STATUS, 32'h1000_0002, "pre_status"});
                    sb.push_back('{S_TIMER, 32'd1, "pre_timer"});
                end
                6: begin
                    sb.push_back('{S_COUNT, 32'd0, "rst_count"});
                    sb.push_back('{S_COMPARE, 32'd0, "rst_compare"});
                    sb.push_back('{S_STATUS, 32'h1000_0000, "rst_status"});
                    sb.push_back('{S_CAUSE, 32'd0, "rst_cause"});
                    sb.push_back('{S_EPC, 32'd0, "rst_epc"});
                    sb.push_back('{S_TIMER, 32'd0, "rst_timer"});
                end
                default: ;
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observe(e.sel) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
        idle();
        int_i = '0;
    endtask

    initial begin
        bus.raddr_i = '0;
        idle();
        rst = 1'b1;
        test_reset();
        $display("test_reset done");
        test_count_wrap();
        $display("test_count_wrap done");
        test_timer();
        $display("test_timer done");
        test_exception();
        $display("test_exception done");
        test_cause_status();
        $display("test_cause_status done");
        test_mid_reset();
        $display("test_mid_reset done");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/risc32_cp0_regfile.md
Name: risc32_cp0_regfile

Overview:
- Coprocessor-0 register file: the responder for the execute stage's CP0 read-address / write-enable/address/data interface.
- Holds Count, Compare, Status, Cause, EPC, PRId and Config.
- Generates the timer interrupt and records exception entry and ERET state.
- Writes arrive from writeback. Reads are served combinationally; execute performs the mem/wb forwarding itself.

Parameters:
PRID_VAL, 32'h004C_0102, constant returned for PRId (reg 15)
CONFIG_RST, 32'h0000_8000, reset/constant value of Config (reg 16, BE=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
we_i  input  1  CP0 write enable (from writeback)
waddr_i  input  5  CP0 write register number
data_i  input  32  CP0 write data
raddr_i  input  5  CP0 read register number (from execute)
int_i  input  6  external hardware interrupt lines
exc_valid_i  input  1  exception taken this cycle
exc_code_i  input  5  ExcCode of the exception
exc_pc_i  input  32  address of the faulting instruction
exc_in_delayslot_i  input  1  faulting instruction is in a delay slot
eret_i  input  1  ERET committed this cycle
data_o  output  32  read data for raddr_i
count_o  output  32  Count
compare_o  output  32  Compare
status_o  output  32  Status
cause_o  output  32  Cause
epc_o  output  32  EPC
timer_int_o  output  1  timer interrupt, sticky

Behaviour:
- Register map: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId (read-only), 16 Config (read-only). Any other address reads 0; writes to it are ignored.
- Reset (rst=1 at a clk edge) loads:
  - Count=0, Compare=0, EPC=0, Cause=0
  - Status=32'h1000_0000 (CU0=1)
  - timer_int_o=0
  - Reset overrides all other inputs in that cycle.
- All state updates on the rising clk edge. data_o is purely combinational from raddr_i and current state; there is no internal write-to-read bypass.
- Count:
  - Increments by 1 every cycle; 32'hFFFF_FFFF wraps to 0.
  - A write to reg 9 loads data_i and suppresses that cycle's increment.
- Compare / timer:
  - A write to reg 11 loads data_i and clears timer_int_o.
  - timer_int_o sets to 1 on the edge following any cycle where Compare!=0 and Count==Compare. It stays set until Compare is written.
  - If set-condition and Compare write coincide, the write wins (timer_int_o=0).
- Status: a write to reg 12 loads all 32 bits.
- Cause:
  - Bits [15:10] (IP7..IP2) are loaded from int_i every cycle and are not software-writable.
  - Writes to reg 13 update only IP1..IP0 [9:8], WP [22] and IV [23]; all other bits are preserved.
- EPC: a write to reg 14 loads data_i.
- Exception entry (exc_valid_i=1):
  - If Status.EXL(bit1)==0:
    - EPC <= exc_in_delayslot_i ? exc_pc_i-4 : exc_pc_i
    - Cause.BD(31) <= exc_in_delayslot_i
    - Status.EXL <= 1
    - Cause.ExcCode[6:2] <= exc_code_i
  - If EXL==1 already: only ExcCode updates; EPC and BD are unchanged.
- ERET (eret_i=1, exc_valid_i=0): Status.EXL <= 0.
- Priority:
  - exc_valid_i over eret_i.
  - Either of them over a same-cycle software write to Status/Cause/EPC; that write is dropped. Cause IP[15:10] sampling still occurs.
  - Count/Compare writes are unaffected by exceptions.
- All outputs reflect registered state; there is no combinational path from write inputs to the count_o..epc_o outputs.

Test Plan:
- Reset, then run 5 idle cycles -> count_o=5, status_o=32'h1000_0000, timer_int_o=0. raddr_i=15 -> data_o=32'h004C_0102; raddr_i=16 -> 32'h0000_8000; raddr_i=3 -> 0.
- Write Count=32'hFFFF_FFFE, then idle 2 cycles -> count_o reads FFFF_FFFE, FFFF_FFFF, 0000_0000 on successive cycles (wrap-around).
- Write Compare=20 with Count=0 -> timer_int_o rises on the edge after count_o==20 and stays high. Write Compare=50 -> timer_int_o=0 next cycle. Repeat with the Compare write landing in the matching cycle -> timer_int_o stays 0.
- exc_valid_i=1, code=5'h08, pc=32'h0000_0100, delayslot=1, EXL=0 -> epc_o=32'h0000_00FC, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1. A second exception with pc=0x200 -> EPC unchanged, ExcCode updated. eret_i -> status_o[1]=0.
- Write Cause=32'hFFFF_FFFF with int_i=6'b101010 -> cause_o=32'h00C0_A B00 pattern, i.e. bits 23,22,9,8 set and [15:10]=101010, all others 0. Write Status together with exc_valid_i -> the Status write is dropped and only EXL sets.
- Assert rst mid-operation (Count=1234, EXL=1, timer_int_o=1) -> next cycle all registers hold their reset values.
